// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// Holds the FSM state encoding, the default operand width and the counter-width function.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A bit counter for a 1-bit operand still needs one flop.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/binary_adder.sv
// Half adder: one-bit sum and carry of two input bits.
module binary_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder_full_adder_cell.sv
// Combinational full adder made from two cascaded half adders.
// The two partial carries can never both be set, so an OR merges them.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic sum_ab;
    logic carry_ab;
    logic carry_s;

    binary_adder u_ha_ab (
        .a     (a),
        .b     (b),
        .sum   (sum_ab),
        .carry (carry_ab)
    );

    binary_adder u_ha_cin (
        .a     (sum_ab),
        .b     (cin),
        .sum   (sum),
        .carry (carry_s)
    );

    assign cout = carry_ab | carry_s;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: accepts an operand pair, adds it LSB-first one bit
// per clock through a single full-adder cell, then presents {carry, sum} until taken.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             busy
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             bit_sum;
    logic             bit_carry;

    full_adder_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry_q),
        .sum  (bit_sum),
        .cout (bit_carry)
    );

    // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    if (WIDTH == 1) begin : g_sum_one
        assign sum_nxt = bit_sum;
    end else begin : g_sum_many
        assign sum_nxt = {bit_sum, sum_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)       state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST)    state_nxt = DONE;
            DONE:    if (out_ready)      state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr    <= a_in;
                        b_sr    <= b_in;
                        sum_sr  <= '0;
                        carry_q <= 1'b0;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    sum_sr  <= sum_nxt;
                    carry_q <= bit_carry;
                    cnt     <= cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake flags come straight from the state register only.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT) || (state == DONE);
    assign sum_out   = sum_sr;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, carry_out8, busy8;
    logic [7:0] a_in8, b_in8, sum_out8;

    logic       in_valid1, in_ready1, out_valid1, out_ready1, carry_out1, busy1;
    logic [0:0] a_in1, b_in1, sum_out1;

    logic [8:0] q8[$];
    logic [1:0] q1[$];

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a_in      (a_in8),
        .b_in      (b_in8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum_out   (sum_out8),
        .carry_out (carry_out8),
        .busy      (busy8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a_in      (a_in1),
        .b_in      (b_in1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum_out   (sum_out1),
        .carry_out (carry_out1),
        .busy      (busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input int hold, input bit inject);
        int         lat;
        logic [8:0] exp;
        logic [7:0] held_sum;
        logic       held_carry;
        a_in8      = a;
        b_in8      = b;
        in_valid8  = 1'b1;
        out_ready8 = (hold == 0);
        check("in_ready8_before_accept", in_ready8, 1);
        q8.push_back({1'b0, a} + {1'b0, b});
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        a_in8     = ~a;
        b_in8     = ~b;
        check("busy8_shift", busy8, 1);
        check("in_ready8_shift", in_ready8, 0);
        lat = 0;
        while (!out_valid8 && lat < 20) begin
            if (inject && lat == 2) begin
                in_valid8 = 1'b1;
                a_in8     = 8'h11;
                b_in8     = 8'h22;
            end else begin
                in_valid8 = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid8 = 1'b0;
        if (!out_valid8) begin
            check("timeout8", 0, 1);
            if (q8.size() > 0) void'(q8.pop_front());
        end else begin
            exp = (q8.size() > 0) ? q8.pop_front() : 9'h1ff;
            check("latency8", lat, 8);
            check("sum8", sum_out8, exp[7:0]);
            check("carry8", carry_out8, exp[8]);
            held_sum   = sum_out8;
            held_carry = carry_out8;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("bp_valid8", out_valid8, 1);
                check("bp_sum8", sum_out8, exp[7:0]);
                check("bp_carry8", carry_out8, held_carry);
                check("bp_in_ready8", in_ready8, 0);
            end
            check("held_sum8", sum_out8, held_sum);
            out_ready8 = 1'b1;
            @(posedge clk); #1;
            check("valid8_drop", out_valid8, 0);
            check("in_ready8_back", in_ready8, 1);
        end
    endtask

    task automatic run1(input logic a, input logic b);
        int         lat;
        logic [1:0] exp;
        a_in1      = a;
        b_in1      = b;
        in_valid1  = 1'b1;
        out_ready1 = 1'b1;
        check("in_ready1_before_accept", in_ready1, 1);
        q1.push_back({1'b0, a} + {1'b0, b});
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid1) begin
            check("timeout1", 0, 1);
            if (q1.size() > 0) void'(q1.pop_front());
        end else begin
            exp = (q1.size() > 0) ? q1.pop_front() : 2'b11;
            check("latency1", lat, 1);
            check("sum1", sum_out1, exp[0]);
            check("carry1", carry_out1, exp[1]);
            @(posedge clk); #1;
            check("valid1_drop", out_valid1, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a_in8 = '0; b_in8 = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; a_in1 = '0; b_in1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready8", in_ready8, 1);
        check("rst_out_valid8", out_valid8, 0);
        check("rst_busy8", busy8, 0);
        check("rst_sum8", sum_out8, 0);
        check("rst_carry8", carry_out8, 0);
        check("rst_in_ready1", in_ready1, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        run8(8'h5A, 8'h3C, 0, 1'b0);
        run8(8'hFF, 8'h01, 0, 1'b0);
        run8(8'hFF, 8'hFF, 0, 1'b0);
        run8(8'h5A, 8'h3C, 5, 1'b0);
        run8(8'h5A, 8'h3C, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run8(8'($urandom_range(255)), 8'($urandom_range(255)), i, 1'b0);
        end

        // Abort in the 4th SHIFT cycle.
        a_in8 = 8'h5A; b_in8 = 8'h3C; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before", busy8, 1);
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid8, 0);
        check("abort_sum", sum_out8, 0);
        check("abort_carry", carry_out8, 0);
        check("abort_busy", busy8, 0);
        check("abort_in_ready", in_ready8, 1);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        run8(8'h03, 8'h04, 0, 1'b0);

        run1(1'b1, 1'b1);
        run1(1'b1, 1'b0);
        run1(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder that accepts two WIDTH-bit operands over a valid/ready handshake and adds them LSB-first, one bit per clock. Each bit uses a single full-adder cell built from two instances of the existing `binary_adder` half adder, with a carry flip-flop. The block sits directly upstream of result consumers and trades throughput for area. It returns the WIDTH-bit sum and final carry over a second valid/ready handshake.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is WIDTH >= 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair on a_in/b_in is valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- sum_out  out  WIDTH  (a_in + b_in) mod 2^WIDTH.
- carry_out  out  1  carry out of bit WIDTH-1.
- busy  out  1  high in SHIFT or DONE.

## Operation
- The clock is one domain; reset is asynchronous, active-high (already decided).
- FSM states:
  - IDLE: in_ready=1. On in_valid at an edge:
    - load a_sr←a_in and b_sr←b_in;
    - clear carry_q, sum_sr and bit counter cnt;
    - go to SHIFT.
  - SHIFT: each edge:
    - s = a_sr[0]^b_sr[0]^carry_q; carry_q ← majority(a_sr[0], b_sr[0], carry_q);
    - a_sr and b_sr shift right by one;
    - s enters sum_sr at the MSB while sum_sr shifts right;
    - cnt increments.
    - On the edge where cnt==WIDTH-1, go to DONE.
  - DONE: out_valid=1. sum_out and carry_out are held stable. On out_ready at an edge, go to IDLE.
- sum_out and carry_out are driven from registers: sum_sr and carry_q, frozen outside SHIFT.
- Arithmetic is unsigned. {carry_out, sum_out} equals a_in + b_in as a WIDTH+1-bit value.
- in_valid in SHIFT or DONE is ignored. Operands are not sampled and no data is corrupted.
- Operands are captured at the accepting edge, so a_in/b_in may change afterward.
- No overlap: a new operand pair can be accepted only after the result handshake completes.
- Reset values:
  - state is IDLE, so in_ready=1;
  - out_valid=0, busy=0;
  - sum_out=0, carry_out=0, cnt=0.
- Reset mid-operation (SHIFT or DONE) aborts immediately; no result is emitted and outputs return to reset values.

## Timing
- Accept at edge k (in_valid & in_ready).
- SHIFT occupies edges k+1 … k+WIDTH.
- out_valid rises after edge k+WIDTH; latency is WIDTH cycles from the accept edge.
- With out_ready held high, out_valid lasts exactly 1 cycle and in_ready rises the next cycle.
- Best-case throughput is one operation per WIDTH+2 cycles.
- Backpressure: out_valid stays high and outputs stay stable for any number of cycles until out_ready.
- in_ready and out_valid are decoded from the state register only; there is no combinational path from in_valid or out_ready.
- cnt width is max(1, $clog2(WIDTH)).
- WIDTH=1: SHIFT lasts one cycle and the terminal-count condition is met immediately.

## Structure
- Shared package serial_adder_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - default WIDTH constant;
  - counter-width helper function.
- Sub-module full_adder_cell: two `binary_adder` instances plus an OR on the two carries. It has no state. It is instantiated once, in the SHIFT datapath.
- Top level contains the FSM, shift registers, carry flip-flop and counter.

## Test plan
- WIDTH=8: a_in=0x5A, b_in=0x3C, out_ready=1 → sum_out=0x96, carry_out=0; out_valid rises exactly 8 cycles after accept and lasts 1 cycle.
- WIDTH=8: 0xFF + 0x01 → sum_out=0x00, carry_out=1. Then 0xFF + 0xFF → sum_out=0xFE, carry_out=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises → sum_out, carry_out and out_valid stay stable, and in_ready stays 0. Raising out_ready → IDLE on the next edge.
- Pulse in_valid with a_in=0x11 and b_in=0x22 during SHIFT of 0x5A+0x3C → ignored; the result is still 0x96.
- Assert rst in the 4th SHIFT cycle → out_valid=0, sum_out=0, carry_out=0, busy=0 and in_ready=1 immediately. A subsequent 0x03+0x04 → 0x07, carry_out=0.
- WIDTH=1: 1+1 → sum_out=0, carry_out=1 with 1-cycle latency. 1+0 → sum_out=1, carry_out=0.
